sad_sequencer: RTL and testbench

- Job-level controller for the 8-bit absolute-difference datapath: accepts a command giving a block length, streams that many pixel pairs through a registered |a-b| stage, and accumulates the sum of absolute differences (SAD).
- Also tracks the maximum single difference and flags when the running sum exceeds a per-job threshold.
- Sits between the motion-search address generator, which issues commands and streams pixels, and the candidate-compare logic, which consumes results.

---
 rtl/sad_pkg.sv | 15 +
 rtl/sad_absdiff_stage.sv | 37 +++
 rtl/sad_sequencer.sv | 143 ++++++++++++++
 tb/tb_sad_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and default widths for the SAD job sequencer.
// Imported by the abs-diff stage and the sequencer top.
package sad_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_LEN_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } sad_state_t;

endpackage

// File: rtl/sad_absdiff_stage.sv
// Registered |a-b| with a valid bit; the first pipeline stage
// of the SAD datapath.
module sad_absdiff_stage
   import sad_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pair_valid,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              d_valid,
   output logic [DATA_W-1:0] d
);

   logic [DATA_W-1:0] diff;

   // Compare-and-subtract so the result never wraps.
   always_comb begin
      diff = (a >= b) ? (a - b) : (b - a);
   end

   // Capture the difference of each accepted pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_valid <= 1'b0;
         d       <= '0;
      end else begin
         d_valid <= pair_valid;
         if (pair_valid) begin
            d <= diff;
         end
      end
   end

endmodule

// File: rtl/sad_sequencer.sv
// Job controller: streams len_m1+1 pixel pairs through the
// abs-diff stage and reports sum, max and over-threshold.
module sad_sequencer
   import sad_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int ACC_W  = DATA_W + LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len_m1,
   input  logic [ACC_W-1:0]  cmd_thresh,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [DATA_W-1:0] pix_a,
   input  logic [DATA_W-1:0] pix_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_sad,
   output logic [DATA_W-1:0] res_max,
   output logic              res_over,
   output logic              busy
);

   sad_state_t        state;
   sad_state_t        state_nxt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt;
   logic [ACC_W-1:0]  thr_q;
   logic [ACC_W-1:0]  acc;
   logic [DATA_W-1:0] max_q;
   logic              s1_valid;
   logic [DATA_W-1:0] s1_d;
   logic              cmd_fire;
   logic              pix_fire;
   logic              res_fire;

   assign cmd_fire = cmd_valid && cmd_ready;
   assign pix_fire = pix_valid && pix_ready;
   assign res_fire = res_valid && res_ready;
   assign busy     = (state != IDLE);

   sad_absdiff_stage #(
      .DATA_W (DATA_W)
   ) u_absdiff (
      .clk        (clk),
      .rst        (rst),
      .pair_valid (pix_fire),
      .a          (pix_a),
      .b          (pix_b),
      .d_valid    (s1_valid),
      .d          (s1_d)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake readies, decoded from state.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      pix_ready = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            pix_ready = 1'b1;
            if (pix_valid && (cnt == len_q)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            if (res_fire) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Job setup, pair counting and stage-2 sum/max accumulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q <= '0;
         thr_q <= '0;
         cnt   <= '0;
         acc   <= '0;
         max_q <= '0;
      end else if (cmd_fire) begin
         len_q <= cmd_len_m1;
         thr_q <= cmd_thresh;
         cnt   <= '0;
         acc   <= '0;
         max_q <= '0;
      end else begin
         if (pix_fire) begin
            cnt <= cnt + LEN_W'(1);
         end
         if (s1_valid) begin
            acc <= acc + ACC_W'(s1_d);
            if (s1_d > max_q) begin
               max_q <= s1_d;
            end
         end
      end
   end

   // Result registers: loaded once in DONE, held until consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_sad   <= '0;
         res_max   <= '0;
         res_over  <= 1'b0;
      end else if ((state == DONE) && !res_valid) begin
         res_valid <= 1'b1;
         res_sad   <= acc;
         res_max   <= max_q;
         res_over  <= (acc > thr_q);
      end else if (res_fire) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sad_sequencer.sv
// Self-checking bench for sad_sequencer: directed scenarios plus
// randomized jobs against a plain-arithmetic SAD model.
module tb_sad_sequencer;

   localparam int DW = 8;
   localparam int LW = 8;
   localparam int AW = DW + LW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [LW-1:0] cmd_len_m1 = '0;
   logic [AW-1:0] cmd_thresh = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic [DW-1:0] pix_a = '0;
   logic [DW-1:0] pix_b = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [AW-1:0] res_sad;
   logic [DW-1:0] res_max;
   logic          res_over;
   logic          busy;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] pa [256];
   logic [DW-1:0] pb [256];

   always #5 clk = ~clk;

   sad_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_len_m1 (cmd_len_m1),
      .cmd_thresh (cmd_thresh),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_a      (pix_a),
      .pix_b      (pix_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sad    (res_sad),
      .res_max    (res_max),
      .res_over   (res_over),
      .busy       (busy)
   );

   // Reference: SAD and max over the first n pairs.
   function automatic void model(input int n, output int sad, output int mx);
      sad = 0;
      mx  = 0;
      for (int i = 0; i < n; i++) begin
         int d;
         d = int'(pa[i]) - int'(pb[i]);
         if (d < 0) d = -d;
         sad += d;
         if (d > mx) mx = d;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input int len_m1, input int thr);
      int t = 0;
      cmd_valid  = 1'b1;
      cmd_len_m1 = LW'(len_m1);
      cmd_thresh = AW'(thr);
      while (!cmd_ready && t < 50) begin
         tick();
         t++;
      end
      if (!cmd_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL cmd_timeout: cmd_ready=%b expected 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic send_pairs(input int n, input int bub);
      int  sent = 0;
      int  t = 0;
      logic acc;
      while (sent < n && t < 5000) begin
         pix_valid = ($urandom_range(99) >= bub);
         pix_a = pa[sent];
         pix_b = pb[sent];
         acc = pix_valid && pix_ready;
         tick();
         if (acc) sent++;
         t++;
      end
      pix_valid = 1'b0;
      if (sent != n) begin
         n_vec++;
         n_err++;
         $display("FAIL pair_timeout: sent %0d expected %0d", sent, n);
      end
   endtask

   task automatic wait_result(output int cyc);
      cyc = 0;
      while (!res_valid && cyc < 1000) begin
         tick();
         cyc++;
      end
      if (!res_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL res_timeout: res_valid=%b expected 1", res_valid);
      end
   endtask

   task automatic finish_result();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++;
      if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      n_vec++;
      if (pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_pix_ready: got %b expected 0", pix_ready); end
      n_vec++;
      if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      n_vec++;
      if (res_sad !== '0 || res_max !== '0 || res_over !== 1'b0) begin
         n_err++;
         $display("FAIL reset_res: got sad=%0d max=%0d over=%b expected 0", res_sad, res_max, res_over);
      end
   endtask

   task automatic test_basic();
      int sad, mx, lat;
      pa[0] = 10;  pb[0] = 3;
      pa[1] = 3;   pb[1] = 10;
      pa[2] = 200; pb[2] = 200;
      pa[3] = 0;   pb[3] = 255;
      model(4, sad, mx);
      send_cmd(3, 100);
      send_pairs(4, 0);
      wait_result(lat);
      n_vec++;
      if (lat != 2) begin n_err++; $display("FAIL basic_latency: got %0d expected 2", lat); end
      n_vec++;
      if (res_sad !== AW'(sad) || sad != 269) begin n_err++; $display("FAIL basic_sad: got %0d expected 269", res_sad); end
      n_vec++;
      if (res_max !== 8'd255) begin n_err++; $display("FAIL basic_max: got %0d expected 255", res_max); end
      n_vec++;
      if (res_over !== 1'b1) begin n_err++; $display("FAIL basic_over: got %b expected 1", res_over); end
      finish_result();
   endtask

   task automatic test_single();
      int lat;
      res_ready = 1'b1;
      pa[0] = 5;
      pb[0] = 9;
      send_cmd(0, 4);
      send_pairs(1, 0);
      wait_result(lat);
      n_vec++;
      if (lat != 2) begin n_err++; $display("FAIL single_latency: got %0d expected 2", lat); end
      n_vec++;
      if (res_sad !== 16'd4 || res_max !== 8'd4) begin
         n_err++;
         $display("FAIL single_sad_max: got sad=%0d max=%0d expected 4/4", res_sad, res_max);
      end
      n_vec++;
      if (res_over !== 1'b0) begin n_err++; $display("FAIL single_over: got %b expected 0", res_over); end
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_done: got %b expected 1", busy); end
      tick();
      res_ready = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL single_release: got busy=%b res_valid=%b cmd_ready=%b expected 0/0/1",
                  busy, res_valid, cmd_ready);
      end
   endtask

   task automatic test_long();
      int sad, mx, lat, thr, extra;
      for (int i = 0; i < 256; i++) begin
         pa[i] = 8'hff;
         pb[i] = 8'h00;
      end
      model(256, sad, mx);
      thr = $urandom_range(65535);
      send_cmd(255, thr);
      send_pairs(256, 30);
      pix_valid = 1'b1;
      extra = 0;
      lat = 0;
      while (!res_valid && lat < 1000) begin
         if (pix_ready) extra++;
         tick();
         lat++;
      end
      pix_valid = 1'b0;
      n_vec++;
      if (extra != 0) begin n_err++; $display("FAIL long_extra_pairs: got %0d expected 0", extra); end
      n_vec++;
      if (lat != 2) begin n_err++; $display("FAIL long_latency: got %0d expected 2", lat); end
      n_vec++;
      if (res_sad !== AW'(sad) || sad != 65280) begin n_err++; $display("FAIL long_sad: got %0d expected 65280", res_sad); end
      n_vec++;
      if (res_over !== (sad > thr)) begin n_err++; $display("FAIL long_over: got %b expected %b", res_over, sad > thr); end
      finish_result();
   endtask

   task automatic test_backpressure();
      int n, n2, sad, mx, thr, lat, sad2, mx2;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
         pa[i] = DW'($urandom);
         pb[i] = DW'($urandom);
      end
      model(n, sad, mx);
      thr = $urandom_range(n * 255);
      send_cmd(n - 1, thr);
      send_pairs(n, 20);
      wait_result(lat);
      n_vec++;
      if (res_sad !== AW'(sad) || res_max !== DW'(mx) || res_over !== (sad > thr)) begin
         n_err++;
         $display("FAIL bp_result: got sad=%0d max=%0d over=%b expected %0d/%0d/%b",
                  res_sad, res_max, res_over, sad, mx, sad > thr);
      end
      n2 = $urandom_range(1, 6);
      cmd_valid  = 1'b1;
      cmd_len_m1 = LW'(n2 - 1);
      cmd_thresh = '1;
      for (int c = 0; c < 5; c++) begin
         pix_valid = 1'b1;
         pix_a = DW'($urandom);
         pix_b = DW'($urandom);
         n_vec++;
         if (res_valid !== 1'b1 || res_sad !== AW'(sad) || res_max !== DW'(mx) ||
             cmd_ready !== 1'b0 || pix_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold_%0d: got v=%b sad=%0d max=%0d cmd_ready=%b pix_ready=%b expected 1/%0d/%0d/0/0",
                     c, res_valid, res_sad, res_max, cmd_ready, pix_ready, sad, mx);
         end
         tick();
      end
      pix_valid = 1'b0;
      res_ready = 1'b1;
      n_vec++;
      if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_cmd_on_handshake: got %b expected 0", cmd_ready); end
      tick();
      res_ready = 1'b0;
      n_vec++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_after_handshake: got cmd_ready=%b res_valid=%b expected 1/0", cmd_ready, res_valid);
      end
      for (int i = 0; i < n2; i++) begin
         pa[i] = DW'($urandom);
         pb[i] = DW'($urandom);
      end
      model(n2, sad2, mx2);
      tick();
      cmd_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL bp_cmd_accepted: busy=%b expected 1", busy); end
      send_pairs(n2, 0);
      wait_result(lat);
      n_vec++;
      if (res_sad !== AW'(sad2) || res_max !== DW'(mx2)) begin
         n_err++;
         $display("FAIL bp_job2: got sad=%0d max=%0d expected %0d/%0d", res_sad, res_max, sad2, mx2);
      end
      finish_result();
   endtask

   task automatic test_idle_pixels();
      int sad, mx, lat;
      for (int c = 0; c < 3; c++) begin
         pix_valid = 1'b1;
         pix_a = 8'hff;
         pix_b = DW'($urandom_range(100));
         n_vec++;
         if (pix_ready !== 1'b0) begin n_err++; $display("FAIL idle_pix_ready_%0d: got %b expected 0", c, pix_ready); end
         tick();
      end
      pix_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pa[i] = DW'($urandom);
         pb[i] = DW'($urandom);
      end
      model(3, sad, mx);
      send_cmd(2, sad);
      send_pairs(3, 0);
      wait_result(lat);
      n_vec++;
      if (res_sad !== AW'(sad) || res_max !== DW'(mx) || res_over !== 1'b0) begin
         n_err++;
         $display("FAIL idle_job: got sad=%0d max=%0d over=%b expected %0d/%0d/0",
                  res_sad, res_max, res_over, sad, mx);
      end
      finish_result();
   endtask

   task automatic test_reset_mid();
      int lat;
      for (int i = 0; i < 4; i++) begin
         pa[i] = 8'hff;
         pb[i] = 8'h00;
      end
      send_cmd(3, 10);
      send_pairs(2, 0);
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (busy !== 1'b0 || pix_ready !== 1'b0 || res_valid !== 1'b0 ||
          res_sad !== '0 || res_max !== '0 || res_over !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_outputs: got busy=%b pix_ready=%b v=%b sad=%0d max=%0d over=%b expected all 0",
                  busy, pix_ready, res_valid, res_sad, res_max, res_over);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      pa[0] = 7;
      pb[0] = 7;
      send_cmd(0, 0);
      send_pairs(1, 0);
      wait_result(lat);
      n_vec++;
      if (res_sad !== '0 || res_max !== '0 || res_over !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_fresh: got sad=%0d max=%0d over=%b expected 0/0/0", res_sad, res_max, res_over);
      end
      finish_result();
   endtask

   task automatic test_random();
      for (int j = 0; j < 8; j++) begin
         int n, sad, mx, thr, lat, w;
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) begin
            pa[i] = DW'($urandom);
            pb[i] = DW'($urandom);
         end
         if (j == 0) begin
            pa[0] = 8'd40;
            pb[0] = 8'd40;
         end
         model(n, sad, mx);
         case (j % 3)
            0: thr = (sad > 0) ? sad - 1 : 0;
            1: thr = sad;
            default: thr = $urandom_range(n * 255);
         endcase
         send_cmd(n - 1, thr);
         send_pairs(n, 25);
         wait_result(lat);
         n_vec++;
         if (lat != 2) begin n_err++; $display("FAIL rnd%0d_latency: got %0d expected 2", j, lat); end
         n_vec++;
         if (res_sad !== AW'(sad) || res_max !== DW'(mx) || res_over !== (sad > thr)) begin
            n_err++;
            $display("FAIL rnd%0d_result: got sad=%0d max=%0d over=%b expected %0d/%0d/%b",
                     j, res_sad, res_max, res_over, sad, mx, sad > thr);
         end
         w = $urandom_range(3);
         repeat (w) tick();
         finish_result();
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_basic();
      test_single();
      test_long();
      test_backpressure();
      test_idle_pixels();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
